// File: rtl/ioblock_bank_if.sv
// Serial configuration port of the I/O bank: shift chain, commit request and status.
interface ioblock_bank_if;
  logic CFG_SE;
  logic CFG_DIN;
  logic CFG_DOUT;
  logic CFG_UPDATE;
  logic CFG_DONE;
  logic CFG_ERR;

  modport master (output CFG_SE, CFG_DIN, CFG_UPDATE,
                  input  CFG_DOUT, CFG_DONE, CFG_ERR);
  modport slave  (input  CFG_SE, CFG_DIN, CFG_UPDATE,
                  output CFG_DOUT, CFG_DONE, CFG_ERR);
endinterface

// File: rtl/ioblock_bank.sv
// Bank of WIDTH programmable I/O cells with a shadow/active serial config chain.
// Optional registered output path built only when IOBANK_OUTREG_EN is defined.
module ioblock_cell (
  input  logic       IOCLK,
  input  logic       RST,
  input  logic [3:0] cfg,     // {OREG, DORREG, TSMUX[1:0]}
  input  logic       ts,
  input  logic       out,
  input  logic       pad_i,
  output logic       pad_o,
  output logic       pad_oe,
  output logic       in_o
);
  logic d_q, ts_e, out_e;

  always_ff @(posedge IOCLK) begin
    if (RST) d_q <= 1'b0;
    else     d_q <= pad_i;
  end

`ifdef IOBANK_OUTREG_EN
  logic ts_q, out_q;
  // Registers run every cycle so a later OREG commit sees the last sampled value.
  always_ff @(posedge IOCLK) begin
    if (RST) begin
      ts_q  <= 1'b0;
      out_q <= 1'b0;
    end else begin
      ts_q  <= ts;
      out_q <= out;
    end
  end
  assign ts_e  = cfg[3] ? ts_q  : ts;
  assign out_e = cfg[3] ? out_q : out;
`else
  logic unused_oreg;
  assign unused_oreg = cfg[3];
  assign ts_e  = ts;
  assign out_e = out;
`endif

  always_comb begin
    pad_oe = 1'b0;
    unique case (cfg[1:0])
      2'b00: pad_oe = 1'b0;
      2'b01: pad_oe = ts_e;
      2'b10: pad_oe = 1'b1;
      2'b11: pad_oe = ~ts_e;
    endcase
  end

  assign pad_o = out_e;
  assign in_o  = cfg[2] ? d_q : pad_i;
endmodule

module ioblock_bank #(
  parameter int WIDTH = 8
) (
  input  logic             IOCLK,
  input  logic             RST,
  inout  wire  [WIDTH-1:0] PIN,
  input  logic [WIDTH-1:0] TS,
  input  logic [WIDTH-1:0] OUT,
  output logic [WIDTH-1:0] IN,
  ioblock_bank_if.slave    cfg
);
  localparam int N  = 4 * WIDTH;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, ARMED} state_e;

  state_e           state, state_nxt;
  logic [N-1:0]     sr, act;
  logic [CW-1:0]    cnt;
  logic             commit, err_set, done_q, err_q;
  logic [WIDTH-1:0] pad_o, pad_oe;

  always_ff @(posedge IOCLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (cfg.CFG_SE) state_nxt = SHIFT;
      SHIFT:   if (cfg.CFG_SE && cnt == CW'(N - 1)) state_nxt = ARMED;
      ARMED:   if (commit) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A commit is only honoured with a full load and no shift in the same cycle.
  always_comb begin
    commit  = (state == ARMED) && cfg.CFG_UPDATE && !cfg.CFG_SE;
    err_set = cfg.CFG_UPDATE && !commit;
  end

  always_ff @(posedge IOCLK) begin
    if (RST) begin
      sr     <= '0;
      act    <= '0;
      cnt    <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      done_q <= commit;
      if (err_set) err_q <= 1'b1;
      if (cfg.CFG_SE) begin
        sr <= {sr[N-2:0], cfg.CFG_DIN};
        if (cnt != CW'(N)) cnt <= cnt + CW'(1);
      end
      if (commit) begin
        act <= sr;
        cnt <= '0;
      end
    end
  end

  assign cfg.CFG_DOUT = sr[N-1];
  assign cfg.CFG_DONE = done_q;
  assign cfg.CFG_ERR  = err_q;

  ioblock_cell u_cell [WIDTH-1:0] (
    .IOCLK  (IOCLK),
    .RST    (RST),
    .cfg    (act),
    .ts     (TS),
    .out    (OUT),
    .pad_i  (PIN),
    .pad_o  (pad_o),
    .pad_oe (pad_oe),
    .in_o   (IN)
  );

  for (genvar k = 0; k < WIDTH; k++) begin : g_pad
    assign PIN[k] = pad_oe[k] ? pad_o[k] : 1'bz;
  end
endmodule

// File: tb/tb_ioblock_bank.sv
// Bench for ioblock_bank: directed steps plus random traffic against a pin-level model.
module tb_ioblock_bank;
  localparam int W = 8;
  localparam int N = 4 * W;
`ifdef IOBANK_OUTREG_EN
  localparam bit OREG_EN = 1'b1;
`else
  localparam bit OREG_EN = 1'b0;
`endif

  logic         IOCLK = 1'b0;
  logic         RST   = 1'b0;
  logic [W-1:0] TS    = '0;
  logic [W-1:0] OUT   = '0;
  logic [W-1:0] IN;
  wire  [W-1:0] PIN;
  logic [W-1:0] ext_en  = '0;
  logic [W-1:0] ext_val = '0;

  ioblock_bank_if cfg ();

  ioblock_bank #(.WIDTH(W)) dut (
    .IOCLK (IOCLK),
    .RST   (RST),
    .PIN   (PIN),
    .TS    (TS),
    .OUT   (OUT),
    .IN    (IN),
    .cfg   (cfg.slave)
  );

  // Pads the model expects undriven are back-driven by the bench so their value is defined.
  for (genvar k = 0; k < W; k++) begin : g_ext
    assign PIN[k] = ext_en[k] ? ext_val[k] : 1'bz;
  end

  always #5 IOCLK = ~IOCLK;

  int ntest = 0;
  int nfail = 0;

  bit           m_sh[$];
  int           m_cnt;
  bit [3:0]     m_act[W];
  bit [W-1:0]   m_d, m_oq, m_tq;
  bit           m_done, m_err;

  function automatic bit eff_ts(int k);
    return (OREG_EN && m_act[k][3]) ? m_tq[k] : TS[k];
  endfunction

  function automatic bit eff_out(int k);
    return (OREG_EN && m_act[k][3]) ? m_oq[k] : OUT[k];
  endfunction

  function automatic bit m_drive(int k);
    case (m_act[k][1:0])
      2'd0:    return 1'b0;
      2'd1:    return eff_ts(k);
      2'd2:    return 1'b1;
      default: return !eff_ts(k);
    endcase
  endfunction

  function automatic bit m_pad(int k);
    return m_drive(k) ? eff_out(k) : ext_val[k];
  endfunction

  task automatic apply();
    for (int k = 0; k < W; k++) ext_en[k] = !m_drive(k);
  endtask

  task automatic model_clock();
    bit [W-1:0] nd;
    bit         commit;
    if (RST) begin
      m_sh.delete();
      repeat (N) m_sh.push_back(1'b0);
      m_cnt = 0; m_d = '0; m_oq = '0; m_tq = '0; m_done = 0; m_err = 0;
      for (int k = 0; k < W; k++) m_act[k] = '0;
    end else begin
      for (int k = 0; k < W; k++) nd[k] = m_pad(k);
      m_d  = nd;
      commit = !cfg.CFG_SE && cfg.CFG_UPDATE && (m_cnt == N);
      if (cfg.CFG_UPDATE && !commit) m_err = 1'b1;
      m_done = commit;
      if (commit) begin
        for (int k = 0; k < W; k++)
          m_act[k] = {m_sh[4*k+3], m_sh[4*k+2], m_sh[4*k+1], m_sh[4*k]};
        m_cnt = 0;
      end
      if (cfg.CFG_SE) begin
        m_sh.push_front(cfg.CFG_DIN);
        void'(m_sh.pop_back());
        m_cnt = (m_cnt < N) ? m_cnt + 1 : N;
      end
      m_oq = OUT;
      m_tq = TS;
    end
  endtask

  task automatic chk(string tag, logic [W-1:0] got, logic [W-1:0] exp);
    ntest++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check(string tag);
    logic [W-1:0] epin, ein;
    for (int k = 0; k < W; k++) begin
      epin[k] = m_pad(k);
      ein[k]  = m_act[k][2] ? m_d[k] : epin[k];
    end
    chk({tag, ".pin"}, PIN, epin);
    chk({tag, ".in"},  IN,  ein);
    chk({tag, ".dout"}, W'(cfg.CFG_DOUT), W'(m_sh[N-1]));
    chk({tag, ".done"}, W'(cfg.CFG_DONE), W'(m_done));
    chk({tag, ".err"},  W'(cfg.CFG_ERR),  W'(m_err));
  endtask

  // One clock: drive inputs, check settled outputs, clock the model alongside the DUT.
  task automatic cyc(string tag, bit se, bit din, bit upd, bit rst, bit do_chk);
    cfg.CFG_SE = se; cfg.CFG_DIN = din; cfg.CFG_UPDATE = upd; RST = rst;
    apply();
    #1;
    if (do_chk) check(tag);
    @(posedge IOCLK);
    model_clock();
    #1;
    apply();
  endtask

  task automatic rnd_io();
    OUT = W'($urandom); TS = W'($urandom); ext_val = W'($urandom);
  endtask

  task automatic load(string tag, logic [N-1:0] w, int from, int to);
    for (int i = from; i < to; i++) begin
      rnd_io();
      cyc(tag, 1'b1, w[N-1-i], 1'b0, 1'b0, 1'b1);
    end
  endtask

  task automatic commit_cfg(string tag);
    cyc(tag, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
  endtask

  initial begin
    logic [N-1:0] w;
    cfg.CFG_SE = 0; cfg.CFG_DIN = 0; cfg.CFG_UPDATE = 0;
    m_sh.delete();
    repeat (N) m_sh.push_back(1'b0);

    // Reset, then idle with an external pattern on the pads
    cyc("reset", 0, 0, 0, 1, 0);
    ext_val = 8'hA5; OUT = W'($urandom); TS = W'($urandom);
    cyc("idle", 0, 0, 0, 0, 1);
    chk("idle_in", IN, 8'hA5);
    chk("idle_flags", {6'd0, cfg.CFG_DONE, cfg.CFG_ERR}, 8'h00);

    // Every pin TSMUX=01
    w = {8{4'b0001}};
    load("ts01_load", w, 0, N);
    commit_cfg("ts01_upd");
    OUT = 8'h3C; TS = 8'h0F; ext_val = W'($urandom);
    cyc("ts01_pads", 0, 0, 0, 0, 1);
    chk("ts01_done", W'(cfg.CFG_DONE), 8'h00);
    apply(); #1;
    chk("ts01_lo", PIN & 8'h0F, 8'h0C);
    repeat (4) begin rnd_io(); cyc("ts01_rnd", 0, 0, 0, 0, 1); end

    // Pin 0: active-low enable with input register
    w = N'($urandom); w[3:0] = 4'b0111;
    load("p0_load", w, 0, N);
    commit_cfg("p0_upd");
    TS[0] = 1'b1; ext_val[0] = 1'b0;
    cyc("p0_lo", 0, 0, 0, 0, 1);
    ext_val[0] = 1'b1; apply(); #1;
    chk("p0_in_before", W'(IN[0]), 8'h00);
    cyc("p0_hi", 0, 0, 0, 0, 1);
    chk("p0_in_after", W'(IN[0]), 8'h01);
    TS[0] = 1'b0; OUT[0] = 1'($urandom); apply(); #1;
    chk("p0_drive", W'(PIN[0]), W'(OUT[0]));
    cyc("p0_drv", 0, 0, 0, 0, 1);

    // Early update sets a sticky error; completed load still commits
    w = N'($urandom);
    load("early_a", w, 0, 17);
    commit_cfg("early_upd");
    cyc("early_err", 0, 0, 0, 0, 1);
    chk("early_err1", W'(cfg.CFG_ERR), 8'h01);
    load("early_b", w, 17, N);
    commit_cfg("late_upd");
    cyc("late_done", 0, 0, 0, 0, 1);
    chk("late_err_sticky", W'(cfg.CFG_ERR), 8'h01);

    // Pin 3 always driven with OREG=1
    w = N'($urandom); w[15:12] = 4'b1010;
    load("oreg_load", w, 0, N);
    commit_cfg("oreg_upd");
    OUT[3] = 1'b0;
    cyc("oreg_0", 0, 0, 0, 0, 1);
    cyc("oreg_0b", 0, 0, 0, 0, 1);
    OUT[3] = 1'b1; apply(); #1;
    chk("oreg_before", W'(PIN[3]), OREG_EN ? 8'h00 : 8'h01);
    cyc("oreg_1", 0, 0, 0, 0, 1);
    chk("oreg_after", W'(PIN[3]), 8'h01);

    // Reset mid-load discards the partial load
    w = N'($urandom) | N'(1) << (N - 1);
    load("mid_load", w, 0, 20);
    cyc("mid_rst", 1, 1, 0, 1, 1);
    cyc("mid_after", 0, 0, 0, 0, 1);
    chk("mid_dout", W'(cfg.CFG_DOUT), 8'h00);
    commit_cfg("mid_upd");
    cyc("mid_err", 0, 0, 0, 0, 1);
    chk("mid_err1", W'(cfg.CFG_ERR), 8'h01);
    w = N'($urandom);
    load("mid_reload", w, 0, N);
    commit_cfg("mid_commit");
    cyc("mid_done", 0, 0, 0, 0, 1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      bit se, upd, rst;
      rnd_io();
      se  = ($urandom_range(0, 3) != 0);
      upd = ($urandom_range(0, 7) == 0);
      rst = ($urandom_range(0, 127) == 0);
      cyc("rnd", se, 1'($urandom), upd, rst, 1);
    end
    #1 check("final");

    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end
endmodule

// File: doc/ioblock_bank.md
# ioblock_bank

Parametrised bank of WIDTH programmable FPGA I/O cells with a serial configuration chain. Each cell drives or tristates its pad under a per-pin 2-bit tristate mode, returns pad data combinationally or through an input register, and optionally registers its output path. Configuration is shifted into a shadow chain and committed atomically, so pad behaviour never changes partway through a load. The bank sits at the fabric/pad boundary and is loaded by the bitstream configuration controller.

## Interface
- WIDTH, 8, number of pins in the bank (1..64)
- Per-pin config is fixed at 4 bits. Chain length N = 4*WIDTH.
- IOCLK  input  1  bank clock; all state updates on its rising edge
- RST  input  1  synchronous, active-high reset
- PIN  inout  WIDTH  pads
- TS  input  WIDTH  per-pin fabric tristate control
- OUT  input  WIDTH  per-pin fabric output data
- IN  output  WIDTH  per-pin data returned to fabric
- CFG_SE  input  1  shift enable for the config chain
- CFG_DIN  input  1  serial config data in
- CFG_DOUT  output  1  serial config data out; equals shadow bit N-1, for daisy-chaining
- CFG_UPDATE  input  1  commit request: shadow to active
- CFG_DONE  output  1  one-cycle pulse after a successful commit
- CFG_ERR  output  1  sticky commit error flag

## Operation
- Shadow chain sr[N-1:0]. When CFG_SE=1, each cycle performs sr <= {sr[N-2:0], CFG_DIN}. The first bit shifted in ends at sr[N-1].
- Pin k fields: sr[4k+1:4k] = TSMUX, sr[4k+2] = DORREG, sr[4k+3] = OREG.
- Active config holds the same layout. Only the active config drives pad behaviour.
- TSMUX per pin:
  - 00: Z.
  - 01: drive when TS=1, Z when TS=0.
  - 10: always drive.
  - 11: drive when TS=0, Z when TS=1 (active-low enable).
- DORREG=0: IN = PIN, combinational. DORREG=1: IN = D, where D captures PIN every IOCLK edge.
- OREG=1: the pad sees registered OUT and TS (one register each per pin). OREG=0: OUT and TS are used combinationally.
- Load counter cnt, 0..N, saturating. It increments on each CFG_SE cycle. Shifting continues past N, with old bits leaving on CFG_DOUT.
- Load FSM:
  - IDLE (cnt=0): CFG_SE moves to SHIFT. If N=1 is impossible (N≥4), it always moves to SHIFT.
  - SHIFT (0<cnt<N): moves to ARMED when cnt reaches N.
  - ARMED (cnt=N): further shifts keep it in ARMED.
  - CFG_UPDATE in ARMED with CFG_SE=0: active <= sr; cnt <= 0; state moves to IDLE; CFG_DONE=1 on the next cycle.
  - CFG_UPDATE in IDLE or SHIFT: ignored (active, cnt and state unchanged); CFG_ERR <= 1.
  - CFG_UPDATE and CFG_SE in the same cycle: the shift happens, the update is ignored, and CFG_ERR <= 1.
- CFG_ERR stays set until RST.

## Timing
- Reset values (RST sampled high on an edge):
  - sr, active config, D, output registers, cnt: 0.
  - State: IDLE. CFG_DONE=0. CFG_ERR=0.
  - Resulting pad behaviour: all PIN=Z; IN=PIN combinational; CFG_DOUT=0.
- RST has priority over CFG_SE and CFG_UPDATE. Reset mid-load discards the partial load.
- Commit latency:
  - The new config takes effect on the edge that samples CFG_UPDATE.
  - CFG_DONE is high during the following cycle only.
  - Output registers are not flushed on commit. The first registered value appears one edge after OREG becomes 1.
- IN latency with DORREG=1: PIN sampled at edge t is visible on IN after edge t.
- Output latency with OREG=1: OUT/TS sampled at edge t drive PIN after edge t.
- CFG_DOUT changes only on shifting edges.

## Configuration
- IOBANK_OUTREG_EN
  - Defined: the OREG bit selects the registered output/tristate path as described above.
  - Undefined: the output registers are not built; OUT/TS are always combinational. The OREG bit still occupies its chain position, is shifted and committed, but has no effect.
- Chain length is identical in both builds.

## Test plan
- Reset then idle, WIDTH=8: all PIN=Z; IN follows an externally driven PIN=8'hA5 in the same cycle; CFG_DONE=0; CFG_ERR=0.
- Shift 32 bits setting every pin to TSMUX=01, DORREG=0, OREG=0, then pulse CFG_UPDATE -> CFG_DONE pulses once; with OUT=8'h3C and TS=8'h0F, PIN=8'bzzzz1100.
- Config pin 0 with TSMUX=11 and DORREG=1, pad externally driven 0→1 at edge t -> IN[0] changes after edge t, not before; TS[0]=0 drives PIN[0]=OUT[0].
- CFG_UPDATE after 17 of 32 shifts -> active config unchanged, CFG_ERR=1 and stays 1; complete the remaining 15 shifts then update -> commit succeeds and CFG_ERR is still 1.
- With IOBANK_OUTREG_EN and OREG=1, TSMUX=10: OUT[3] toggles at edge t -> PIN[3] changes after edge t. Without the macro -> PIN[3] changes combinationally.
- RST asserted after 20 shifts -> cnt=0, state IDLE, CFG_DOUT=0; a subsequent CFG_UPDATE sets CFG_ERR=1.
